// File: rtl/fpu_sgnj_operand_stage_pkg.sv
// Shared FPU definitions: sign-injection funct3 codes, formats, canonical NaNs
// and IEEE field widths selected by register-file width.
package fpu_sgnj_operand_stage_pkg;

    typedef enum logic [2:0] {
        SGNJ  = 3'b000,
        SGNJN = 3'b001,
        SGNJX = 3'b010
    } sgnj_op_e;

    typedef enum logic {
        FMT_S = 1'b0,
        FMT_D = 1'b1
    } fp_fmt_e;

    localparam logic [31:0] CANON_NAN_S = 32'h7FC0_0000;
    localparam logic [63:0] CANON_NAN_D = 64'h7FF8_0000_0000_0000;

    localparam int unsigned EXP_W_S = 8;
    localparam int unsigned MAN_W_S = 23;
    localparam int unsigned EXP_W_D = 11;
    localparam int unsigned MAN_W_D = 52;

    function automatic int unsigned exp_w(input int unsigned bus_width);
        return (bus_width == 64) ? EXP_W_D : EXP_W_S;
    endfunction

    function automatic int unsigned man_w(input int unsigned bus_width);
        return (bus_width == 64) ? MAN_W_D : MAN_W_S;
    endfunction

endpackage

// File: rtl/fpu_sgnj_operand_stage_nan_unbox.sv
// Combinational NaN-unbox of one FLEN-wide operand; single-precision values
// come out right-aligned with zeroed upper bits, or as canonical NaN if not boxed.
module fpu_nan_unbox
    import fpu_sgnj_operand_stage_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 64
) (
    input  logic [BUS_WIDTH-1:0] op_i,
    input  logic                 is_single_i,
    output logic [BUS_WIDTH-1:0] op_o
);

    generate
        if (BUS_WIDTH == 64) begin : g_box
            always_comb begin
                op_o = op_i;
                if (is_single_i) begin
                    if (&op_i[63:32]) begin
                        op_o = {32'h0, op_i[31:0]};
                    end else begin
                        op_o = {32'h0, CANON_NAN_S};
                    end
                end
            end
        end else begin : g_nobox
            // A 32-bit register file holds singles natively; nothing to unbox.
            logic unused_single;
            assign unused_single = is_single_i;
            assign op_o          = op_i;
        end
    endgenerate

endmodule

// File: rtl/fpu_sgnj_operand_stage.sv
// FSGNJ operand-preparation stage: unbox, fold funct3 into operand-2 sign,
// and buffer in a 2-entry FIFO whose outputs come straight from registers.
module fpu_sgnj_operand_stage
    import fpu_sgnj_operand_stage_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 64,
    parameter int unsigned TAG_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_funct3,
    input  logic                 in_fmt,
    input  logic [BUS_WIDTH-1:0] in_rs1,
    input  logic [BUS_WIDTH-1:0] in_rs2,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] out_in1,
    output logic [BUS_WIDTH-1:0] out_in2,
    output logic                 out_fmt,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_illegal
);

    localparam int unsigned SIGN_S = EXP_W_S + MAN_W_S;
    localparam int unsigned SIGN_D = exp_w(BUS_WIDTH) + man_w(BUS_WIDTH);

    typedef struct packed {
        logic [BUS_WIDTH-1:0] in1;
        logic [BUS_WIDTH-1:0] in2;
        logic                 fmt;
        logic [TAG_W-1:0]     tag;
        logic                 illegal;
    } entry_t;

    logic                 is_dbl;
    logic [BUS_WIDTH-1:0] op1_ub;
    logic [BUS_WIDTH-1:0] op2_ub;
    entry_t               wr_entry;

    entry_t               mem_q [2];
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [1:0]           count_q,  count_d;
    logic                 push, pop;

    assign is_dbl = (BUS_WIDTH == 64) && (in_fmt == FMT_D);

    fpu_nan_unbox #(.BUS_WIDTH(BUS_WIDTH)) u_unbox_rs1 (
        .op_i        (in_rs1),
        .is_single_i (!is_dbl),
        .op_o        (op1_ub)
    );

    fpu_nan_unbox #(.BUS_WIDTH(BUS_WIDTH)) u_unbox_rs2 (
        .op_i        (in_rs2),
        .is_single_i (!is_dbl),
        .op_o        (op2_ub)
    );

    always_comb begin
        wr_entry.in1     = op1_ub;
        wr_entry.in2     = op2_ub;
        wr_entry.fmt     = is_dbl;
        wr_entry.tag     = in_tag;
        wr_entry.illegal = 1'b0;
        case (in_funct3)
            SGNJ: begin
            end
            SGNJN: begin
                if (is_dbl) wr_entry.in2[SIGN_D] = ~op2_ub[SIGN_D];
                else        wr_entry.in2[SIGN_S] = ~op2_ub[SIGN_S];
            end
            SGNJX: begin
                if (is_dbl) wr_entry.in2[SIGN_D] = op1_ub[SIGN_D] ^ op2_ub[SIGN_D];
                else        wr_entry.in2[SIGN_S] = op1_ub[SIGN_S] ^ op2_ub[SIGN_S];
            end
            default: wr_entry.illegal = 1'b1;
        endcase
    end

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            for (int unsigned i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push && !flush) begin
                mem_q[wr_ptr_q] <= wr_entry;
            end
        end
    end

    assign out_in1     = mem_q[rd_ptr_q].in1;
    assign out_in2     = mem_q[rd_ptr_q].in2;
    assign out_fmt     = mem_q[rd_ptr_q].fmt;
    assign out_tag     = mem_q[rd_ptr_q].tag;
    assign out_illegal = mem_q[rd_ptr_q].illegal;

endmodule

// File: doc/fpu_sgnj_operand_stage.md
Name: fpu_sgnj_operand_stage

Overview:
Registered operand-preparation stage directly upstream of the combinational sign-injection unit (FSGNJ) in the FPU. It accepts FSGNJ/FSGNJN/FSGNJX issue requests over a valid/ready handshake and NaN-unboxes single-precision operands held in FLEN-wide registers. It pre-folds the funct3 variant into the sign bit of operand 2, so the downstream unit always performs plain sign injection. Results are buffered in a 2-entry skid buffer to decouple issue from the FPU result path.

Parameters:
BUS_WIDTH, 64, FLEN of the FP register file (64 or 32).
TAG_W, 5, width of the destination-register tag carried alongside operands.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush
in_valid  in  1  request valid
in_ready  out  1  stage can accept a request
in_funct3  in  3  000=FSGNJ, 001=FSGNJN, 010=FSGNJX
in_fmt  in  1  0=single, 1=double (ignored when BUS_WIDTH=32; treated as single)
in_rs1  in  BUS_WIDTH  operand 1 raw register value
in_rs2  in  BUS_WIDTH  operand 2 raw register value
in_tag  in  TAG_W  destination tag
out_valid  out  1  head entry valid
out_ready  in  1  downstream consumes head
out_in1  out  BUS_WIDTH  prepared operand 1
out_in2  out  BUS_WIDTH  prepared operand 2 (sign pre-folded)
out_fmt  out  1  format of head entry
out_tag  out  TAG_W  tag of head entry
out_illegal  out  1  funct3 not in {000,001,010}

Behaviour:
- Reset (rst_n=0, asynchronous): count=0, out_valid=0, in_ready=1; all out_* data and flags = 0. Reset mid-transfer discards all entries.
- Storage: 2-entry FIFO (wr/rd pointers, 2-bit count). in_ready = (count!=2). out_valid = (count!=0). Outputs are driven from the head entry register and carry no combinational path from the in_* ports.
- Accept: in_valid && in_ready at a rising edge. Pop: out_valid && out_ready. Simultaneous accept and pop leaves count unchanged. A pop at count=2 frees the slot for a push only on the next cycle (in_ready is not combinationally driven by out_ready).
- Latency: a request accepted at edge N appears on out_* after edge N when the buffer was empty. Sustained throughput is 1 per cycle while out_ready=1.
- Flush: at the edge, count:=0 and out_valid:=0. Flush takes priority over a simultaneous accept or pop; both are dropped.
- Unboxing (combinational before write): when BUS_WIDTH=64 and fmt=0, an operand whose bits [63:32] are not all ones is replaced by canonical NaN 32'h7FC00000. The 32-bit value is stored right-aligned with bits [63:32]=0. Doubles pass through unchanged.
- Sign fold, with sign bit position p = 31 (single) or BUS_WIDTH-1 (double):
  - J: in2 unchanged.
  - JN: in2[p] := ~in2[p].
  - JX: in2[p] := in1[p] ^ in2[p].
  - Folding is applied after unboxing.
- Illegal funct3: the request is still accepted; out_illegal=1; in2 passes unboxed and unfolded.
- Bits of out_in1/out_in2 above p are 0 for single. Downstream uses a 32-bit FSGNJ instance for single and reboxes at writeback.

Decomposition:
- Shared FPU package holds:
  - funct3 constants SGNJ/SGNJN/SGNJX
  - FMT_S/FMT_D
  - canonical NaN constants (32'h7FC00000, 64'h7FF8000000000000)
  - EXP/MANTISSA width localparams keyed on BUS_WIDTH
- One natural sub-module: fpu_nan_unbox (combinational per-operand unbox). It is instantiated twice and is reusable by other FPU issue stages.

Test Plan:
- Double FSGNJN, rs1=64'h3FF0000000000000, rs2=64'h4000000000000000, out_ready=1 -> next cycle out_valid=1, out_in2=64'hC000000000000000, out_in1 unchanged, out_illegal=0.
- Single FSGNJX boxed: rs1=64'hFFFFFFFF_BF800000, rs2=64'hFFFFFFFF_C0000000 -> out_in1=64'h00000000_BF800000, out_in2=64'h00000000_40000000.
- Single improperly boxed: rs1=64'h00000000_3F800000, funct3=000 -> out_in1=64'h00000000_7FC00000.
- Backpressure: out_ready=0 with 3 back-to-back requests -> in_ready=0 after 2 accepts, third held. Then out_ready=1 -> entries emerge in order with tags 1,2,3.
- Flush with count=2 plus simultaneous in_valid -> next cycle out_valid=0, in_ready=1, new request not stored.
- funct3=011, then rst_n pulse low mid-stream -> out_illegal=1 on that entry. Reset clears out_valid asynchronously; all outputs are 0.
